accum_sequencer: RTL and testbench

Control sequencer for the 16-bit switch accumulator datapath (operand mux, 17-bit register, adder). It turns one press of the Run button into a burst of N register loads, which accumulates the operand N times (repeated-addition multiply). It snapshots the operand for the length of the burst, tracks carry-out as a sticky overflow flag, and handles Clear. It replaces the single-shot run control between the inverted button signals and the register/router.

---
 rtl/accum_pkg.sv | 7 +
 rtl/accum_sequencer_rise_detect.sv | 19 +
 rtl/accum_sequencer.sv | 97 +++++++++
 tb/tb_accum_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and sizes for the switch accumulator sequencer.
package accum_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/accum_sequencer_rise_detect.sv
// Rising-edge detector for a level input such as a button.
// The held level resets high, so a button already pressed when reset
// releases is not seen as a fresh press.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Rise
);
  logic in_q;

  // Remember last cycle's level
  always_ff @(posedge Clk) begin
    if (Reset) in_q <= 1'b1;
    else       in_q <= In;
  end

  assign Rise = In & ~in_q;
endmodule

// File: rtl/accum_sequencer.sv
// Burst sequencer for the switch accumulator: one Run press issues N
// register loads of a snapshotted operand, with sticky carry overflow
// and a Clear that overrides everything except Reset.
module accum_sequencer #(
  parameter int WIDTH = accum_pkg::WIDTH,
  parameter int CNT_W = accum_pkg::CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Op_In,
  input  logic [CNT_W-1:0] Repeat,
  input  logic             Carry,
  output logic [WIDTH-1:0] Op_Out,
  output logic             Load,
  output logic             Clear_Reg,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);
  import accum_pkg::*;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             run_rise;
  logic             start;

  rise_detect u_run_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (Run),
    .Rise  (run_rise)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and Moore outputs; Clear overrides the transition and load
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    Load      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (run_rise) begin
          state_nxt = ACCUM;
          start     = 1'b1;
        end
      end
      ACCUM: begin
        Busy = 1'b1;
        Load = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (Clear) begin
      state_nxt = IDLE;
      start     = 1'b0;
      Load      = 1'b0;
    end
  end

  // Register clear is idempotent, so it simply follows Clear
  assign Clear_Reg = Clear;

  // Burst counter and operand snapshot; operand holds through Clear
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt    <= '0;
      Op_Out <= '0;
    end else if (Clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt    <= (Repeat == '0) ? CNT_W'(1) : Repeat;
      Op_Out <= Op_In;
    end else if (state == ACCUM) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Sticky overflow from any load whose sum carries out
  always_ff @(posedge Clk) begin
    if (Reset || Clear)  Overflow <= 1'b0;
    else if (Load && Carry) Overflow <= 1'b1;
  end
endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: directed scenarios plus random traffic, with a
// behavioural model of the burst rules and of the 17-bit register datapath.
module tb_accum_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset, Run, Clear, Carry;
  logic [WIDTH-1:0] Op_In, Op_Out;
  logic [CNT_W-1:0] Repeat;
  logic             Load, Clear_Reg, Busy, Done, Overflow;

  // Environment register and adder, driven by the DUT's controls
  logic [WIDTH:0]   acc = '0;
  logic [WIDTH:0]   sum;
  int               nload = 0;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // Model state: loads still owed, done flag, snapshot, overflow, last Run
  int             m_left = 0;
  bit             m_done = 1'b0, m_ovf = 1'b0, m_prev = 1'b1;
  logic [WIDTH-1:0] m_op = '0;
  logic [WIDTH:0]   m_acc = '0;

  always #5 Clk = ~Clk;

  accum_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .Clear     (Clear),
    .Op_In     (Op_In),
    .Repeat    (Repeat),
    .Carry     (Carry),
    .Op_Out    (Op_Out),
    .Load      (Load),
    .Clear_Reg (Clear_Reg),
    .Busy      (Busy),
    .Done      (Done),
    .Overflow  (Overflow)
  );

  assign sum   = {1'b0, acc[WIDTH-1:0]} + {1'b0, Op_Out};
  assign Carry = sum[WIDTH];

  always @(posedge Clk) begin
    if (Clear_Reg) acc <= '0;
    else if (Load) acc <= sum;
    if (Load) nload <= nload + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a press buys max(Repeat,1) loads starting next cycle, then a
  // done phase lasting until Run is seen low; Clear cancels everything.
  always @(posedge Clk) begin
    logic [WIDTH:0] ms;
    bit ld;
    ms = {1'b0, m_acc[WIDTH-1:0]} + {1'b0, m_op};
    ld = (m_left > 0) && !Clear;
    if (Clear)   m_acc = '0;
    else if (ld) m_acc = ms;
    if (Reset) begin
      m_left = 0; m_done = 1'b0; m_ovf = 1'b0; m_op = '0; m_prev = 1'b1;
    end else begin
      if (ld && ms[WIDTH]) m_ovf = 1'b1;
      if (Clear) begin
        m_left = 0; m_done = 1'b0; m_ovf = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (m_done) begin
        if (!Run) m_done = 1'b0;
      end else if (Run && !m_prev) begin
        m_left = (Repeat == 0) ? 1 : int'(Repeat);
        m_op   = Op_In;
      end
      m_prev = Run;
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("load",  32'(Load),      32'((m_left > 0) && !Clear));
      chk("busy",  32'(Busy),      32'(m_left > 0));
      chk("done",  32'(Done),      32'(m_done));
      chk("clr",   32'(Clear_Reg), 32'(Clear));
      chk("op",    32'(Op_Out),    32'(m_op));
      chk("ovf",   32'(Overflow),  32'(m_ovf));
      chk("acc",   32'(acc),       32'(m_acc));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clr1();
    Clear = 1'b1; cyc(1); Clear = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Clear = 1'b0; Op_In = '0; Repeat = '0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_load", 32'(Load), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_ovf",  32'(Overflow), 32'h0);
    chk("rst_op",   32'(Op_Out), 32'h0);
    Reset = 1'b0;
    cyc(1);

    // 5 x 3
    Op_In = 16'h0005; Repeat = 4'd3; nload = 0; Run = 1'b1;
    cyc(4);
    chk("sc1_done", 32'(Done), 32'h1);
    Run = 1'b0; cyc(3);
    chk("sc1_loads", 32'(nload), 32'd3);
    chk("sc1_acc", 32'(acc), 32'h0000F);

    // Repeat 0 behaves as 1
    clr1();
    Op_In = 16'h0007; Repeat = 4'd0; nload = 0; Run = 1'b1;
    cyc(2); Run = 1'b0; cyc(3);
    chk("sc2_loads", 32'(nload), 32'd1);
    chk("sc2_acc", 32'(acc), 32'h00007);

    // Carry out sets sticky overflow; Clear drops it
    clr1();
    Op_In = 16'hFFFF; Repeat = 4'd2; Run = 1'b1;
    cyc(3); Run = 1'b0; cyc(3);
    chk("sc3_ovf", 32'(Overflow), 32'h1);
    chk("sc3_acc", 32'(acc), 32'h1FFFE);
    Clear = 1'b1; cyc(1);
    chk("sc3_clr_ovf", 32'(Overflow), 32'h0);
    Clear = 1'b0; cyc(1);
    chk("sc3_clrreg", 32'(Clear_Reg), 32'h0);

    // Operand change mid-burst is ignored
    Op_In = 16'h0001; Repeat = 4'd4; Run = 1'b1;
    cyc(2); Op_In = 16'h0100; cyc(4); Run = 1'b0; cyc(2);
    chk("sc4_acc", 32'(acc), 32'h00004);
    chk("sc4_op", 32'(Op_Out), 32'h0001);

    // Clear in 2nd burst cycle with Run held
    clr1();
    Op_In = 16'h0003; Repeat = 4'd5; nload = 0; Run = 1'b1;
    cyc(2); Clear = 1'b1; cyc(1); Clear = 1'b0;
    chk("sc5_busy", 32'(Busy), 32'h0);
    cyc(4);
    chk("sc5_loads", 32'(nload), 32'd1);
    Run = 1'b0; cyc(1); Run = 1'b1; cyc(7); Run = 1'b0; cyc(2);
    chk("sc5_reloads", 32'(nload), 32'd6);

    // Run held through reset; reset mid-burst
    Run = 1'b1; Reset = 1'b1; cyc(2); Reset = 1'b0; nload = 0; cyc(3);
    chk("sc6_noload", 32'(nload), 32'd0);
    Run = 1'b0; cyc(1); Repeat = 4'd6; Run = 1'b1; cyc(3);
    Reset = 1'b1; cyc(1);
    chk("sc6_busy", 32'(Busy), 32'h0);
    Reset = 1'b0; nload = 0; cyc(3);
    chk("sc6_after", 32'(nload), 32'd0);
    Run = 1'b0; cyc(1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      Reset  = ($urandom_range(0, 99) == 0);
      Clear  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) Run = ~Run;
      Op_In  = WIDTH'($urandom());
      Repeat = CNT_W'($urandom_range(0, 15));
      cyc(1);
    end
    Reset = 1'b0; Clear = 1'b0; Run = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
